// File: rtl/irq_trap_arbiter.sv
// Machine interrupt arbiter: synchronises IRQ lines, masks with mie/mstatus.MIE,
// picks the highest-priority cause and tracks the trap request until mret.
module irq_trap_arbiter #(
    parameter int unsigned NUM_LOCAL   = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned LOC_W      = (NUM_LOCAL > 0) ? NUM_LOCAL : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_sw_i,
    input  logic             irq_timer_i,
    input  logic             irq_ext_i,
    input  logic [LOC_W-1:0] irq_local_i,
    input  logic [31:0]      mie_i,
    input  logic             mstatus_mie_i,
    input  logic             exception_i,
    input  logic             stall_i,
    input  logic             m_ret_i,
    output logic             trap_o,
    output logic [31:0]      cause_o,
    output logic [31:0]      mip_o,
    output logic             in_handler_o
);

    localparam int unsigned NIRQ   = 3 + LOC_W;
    localparam int unsigned CODE_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HANDLER
    } state_t;

    state_t              state_q, state_n;
    logic [NIRQ-1:0]     irq_raw, irq_s;
    logic [31:0]         pend_c, elig_c;
    logic [CODE_W-1:0]   code_c;
    logic                any_c;
    logic                latch_c;

    assign irq_raw = {irq_local_i, irq_ext_i, irq_timer_i, irq_sw_i};

    // Input synchroniser chain; bypassed when sources are already in this clock domain
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_s = irq_raw;
        end else begin : g_sync
            logic [NIRQ-1:0] stage_q [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= irq_raw;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
                end
            end
            assign irq_s = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    // Map synchronised lines onto mip bit positions
    always_comb begin
        pend_c     = '0;
        pend_c[3]  = irq_s[0];
        pend_c[7]  = irq_s[1];
        pend_c[11] = irq_s[2];
        for (int i = 0; i < int'(NUM_LOCAL); i++) pend_c[16+i] = irq_s[3+i];
    end

    // Priority pick: later assignments override, so lowest-priority sources go first
    always_comb begin
        elig_c = pend_c & mie_i & {32{mstatus_mie_i}};
        any_c  = |elig_c;
        code_c = '0;
        for (int i = int'(NUM_LOCAL) - 1; i >= 0; i--) begin
            if (elig_c[16+i]) code_c = CODE_W'(16 + i);
        end
        if (elig_c[7])  code_c = CODE_W'(7);
        if (elig_c[3])  code_c = CODE_W'(3);
        if (elig_c[11]) code_c = CODE_W'(11);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        latch_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_c && !exception_i) begin
                    state_n = S_REQ;
                    latch_c = 1'b1;
                end
            end
            S_REQ:     state_n = stall_i ? S_WAIT : S_HANDLER;
            S_WAIT:    if (!stall_i) state_n = S_HANDLER;
            S_HANDLER: if (m_ret_i && !stall_i) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Registered outputs follow the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_o       <= 1'b0;
            in_handler_o <= 1'b0;
            cause_o      <= '0;
            mip_o        <= '0;
        end else begin
            trap_o       <= (state_n == S_REQ);
            in_handler_o <= (state_n == S_HANDLER);
            mip_o        <= pend_c;
            if (latch_c) cause_o <= {1'b1, 31'(code_c)};
        end
    end

endmodule
